bus_select_sequencer: RTL

- Timing and control stage that drives the 3-bit Selection input of the common-bus 8x1 data multiplexer.
- Also drives the register load/increment strobes for one basic-computer instruction cycle.
- Holds a 3-bit sequence counter (T0..T6) and latches the opcode and indirect bit from IR.
- Sequences fetch, decode, indirect-address and memory-reference execution, and hands register-reference instructions to the downstream register-reference logic.

---
 rtl/bus_select_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bus_select_sequencer.sv
// bus_select_sequencer
//   Timing and control stage for one basic-computer instruction cycle. It drives
//   the 3-bit Selection input of the common-bus 8x1 multiplexer and the register
//   load/increment and memory strobes. The sequence counter steps T0..T6. The
//   opcode and indirect bit are latched from IR at the end of T2.
//
// Ports
//   Clock, Reset     rising-edge clock, asynchronous active-high reset
//   Start            one-cycle pulse; leaves halt and begins fetch at T0
//   IR               instruction register contents, valid from T2
//   DR_zero          DR == 0, sampled in T6 of ISZ
//   Selection        bus source: 0 none,1 AR,2 PC,3 DR,4 AC,5 IR,6 TR,7 Memory
//   *_load/*_inc     register strobes, applied at the next Clock edge
//   Mem_read/write   memory strobes
//   ALU_op           0 AND, 1 ADD, 2 LOAD(DR), 3 none
//   RegRef_exec      register-reference execute pulse (downstream decodes IR[11:0])
//   Running, SC      sequencing state, exported for debug/bench visibility
//
// All outputs are Moore-decoded from {Running, SC, Op, I}, so the asynchronous
// reset forces every strobe low as soon as Reset rises. The one exception is the
// ISZ T6 PC_inc, which is additionally qualified by DR_zero.
module bus_select_sequencer #(
  parameter int W    = 16,
  parameter int SC_W = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [W-1:0]    IR,
  input  logic            DR_zero,
  output logic [2:0]      Selection,
  output logic            AR_load,
  output logic            AR_inc,
  output logic            PC_load,
  output logic            PC_inc,
  output logic            DR_load,
  output logic            DR_inc,
  output logic            AC_load,
  output logic            IR_load,
  output logic            Mem_read,
  output logic            Mem_write,
  output logic [1:0]      ALU_op,
  output logic            RegRef_exec,
  output logic            Running,
  output logic [SC_W-1:0] SC
);

  logic            r_running;
  logic [SC_W-1:0] r_sc;
  logic [2:0]      r_op;
  logic            r_i;

  logic            w_running_nxt;
  logic [SC_W-1:0] w_sc_nxt;
  logic            w_clear;
  logic            w_halt;

  // Only the opcode, indirect bit and IR[0] (HLT) matter at this stage.
  logic            w_unused_ir;
  assign w_unused_ir = ^IR[W-5:1];

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_running <= 1'b0;
      r_sc      <= '0;
      r_op      <= 3'd0;
      r_i       <= 1'b0;
    end else begin
      r_running <= w_running_nxt;
      r_sc      <= w_sc_nxt;
      if (r_running && (r_sc == SC_W'(2))) begin
        r_op <= IR[W-2:W-4];
        r_i  <= IR[W-1];
      end
    end
  end

  // Next-state logic. Start is only honoured while halted, so a Start that
  // coincides with the HLT clear leaves the block halted.
  always_comb begin
    w_running_nxt = r_running;
    w_sc_nxt      = r_sc;
    if (!r_running) begin
      w_sc_nxt = '0;
      if (Start) w_running_nxt = 1'b1;
    end else begin
      w_sc_nxt = w_clear ? '0 : r_sc + SC_W'(1);
      if (w_halt) w_running_nxt = 1'b0;
    end
  end

  // Output decode. Step/opcode pairs that cannot occur fall through to clear,
  // which also covers a forced SC of 7.
  always_comb begin
    Selection   = 3'd0;
    AR_load     = 1'b0;
    AR_inc      = 1'b0;
    PC_load     = 1'b0;
    PC_inc      = 1'b0;
    DR_load     = 1'b0;
    DR_inc      = 1'b0;
    AC_load     = 1'b0;
    IR_load     = 1'b0;
    Mem_read    = 1'b0;
    Mem_write   = 1'b0;
    ALU_op      = 2'd3;
    RegRef_exec = 1'b0;
    w_clear     = 1'b0;
    w_halt      = 1'b0;
    if (r_running) begin
      case (r_sc)
        SC_W'(0): begin Selection = 3'd2; AR_load = 1'b1; end
        SC_W'(1): begin Selection = 3'd7; Mem_read = 1'b1; IR_load = 1'b1; PC_inc = 1'b1; end
        SC_W'(2): begin Selection = 3'd5; AR_load = 1'b1; end
        SC_W'(3): begin
          if (r_op != 3'd7) begin
            if (r_i) begin Selection = 3'd7; Mem_read = 1'b1; AR_load = 1'b1; end
          end else begin
            w_clear = 1'b1;
            if (!r_i) begin
              RegRef_exec = 1'b1;
              w_halt      = IR[0];
            end
          end
        end
        SC_W'(4): begin
          case (r_op)
            3'd0, 3'd1, 3'd2, 3'd6: begin Selection = 3'd7; Mem_read = 1'b1; DR_load = 1'b1; end
            3'd3: begin Selection = 3'd4; Mem_write = 1'b1; w_clear = 1'b1; end
            3'd4: begin Selection = 3'd1; PC_load = 1'b1; w_clear = 1'b1; end
            3'd5: begin Selection = 3'd2; Mem_write = 1'b1; AR_inc = 1'b1; end
            default: w_clear = 1'b1;
          endcase
        end
        SC_W'(5): begin
          case (r_op)
            3'd0, 3'd1, 3'd2: begin AC_load = 1'b1; ALU_op = r_op[1:0]; w_clear = 1'b1; end
            3'd5: begin Selection = 3'd1; PC_load = 1'b1; w_clear = 1'b1; end
            3'd6: DR_inc = 1'b1;
            default: w_clear = 1'b1;
          endcase
        end
        SC_W'(6): begin
          w_clear = 1'b1;
          if (r_op == 3'd6) begin
            Selection = 3'd3;
            Mem_write = 1'b1;
            PC_inc    = DR_zero;
          end
        end
        default: w_clear = 1'b1;
      endcase
    end
  end

  assign Running = r_running;
  assign SC      = r_sc;

endmodule
